// File: rtl/cv32e41s_pkg.sv
// ---------------------------------------------------------------------------
// cv32e41s_pkg
// Types and constants shared by the instruction-side OBI gasket.
//   obi_inst_req_t  : address-phase payload {addr, prot} driven onto OBI
//   obi_inst_resp_t : response payload {rdata, err} forwarded upstream
//   gasket_state_e  : TRANSPARENT / REGISTERED address-phase state
//   INSTR_PROT_FETCH: prot[0] value that marks an instruction fetch
// ---------------------------------------------------------------------------
package cv32e41s_pkg;

  localparam logic INSTR_PROT_FETCH = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } obi_inst_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_inst_resp_t;

  typedef enum logic {
    TRANSPARENT = 1'b0,
    REGISTERED  = 1'b1
  } gasket_state_e;

endpackage

// File: rtl/cv32e41s_instr_obi_gasket.sv
// ---------------------------------------------------------------------------
// cv32e41s_instr_obi_gasket
// Bridges the prefetcher transaction interface onto the OBI instruction bus.
// A raised OBI request is held stable until granted, granted-but-unanswered
// transactions are counted and the prefetcher is throttled at the limit,
// responses are forwarded with zero latency, and a response arriving with
// nothing outstanding raises a sticky protocol error.
//
// Ports:
//   clk, rst                 clock / asynchronous active-high reset
//   trans_valid_i/ready_o    prefetcher request handshake
//   trans_addr_i, priv_i     request address (bits [1:0] dropped) and privilege
//   obi_req_o, obi_gnt_i     OBI address-phase handshake
//   obi_addr_o, obi_prot_o   OBI word address and {priv, fetch} protection
//   obi_rvalid_i, rdata_i,
//   obi_err_i                OBI response phase
//   resp_valid_o, rdata_o,
//   resp_err_o               response forwarded to the alignment buffer
//   outstnd_cnt_o            granted-but-unanswered transaction count
//   busy_o                   something outstanding or a request held
//   protocol_err_o           sticky unsolicited-response flag
// ---------------------------------------------------------------------------
module cv32e41s_instr_obi_gasket
  import cv32e41s_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trans_valid_i,
  output logic                 trans_ready_o,
  input  logic [31:0]          trans_addr_i,
  input  logic [1:0]           trans_priv_i,
  output logic                 obi_req_o,
  input  logic                 obi_gnt_i,
  output logic [31:0]          obi_addr_o,
  output logic [2:0]           obi_prot_o,
  input  logic                 obi_rvalid_i,
  input  logic [31:0]          obi_rdata_i,
  input  logic                 obi_err_i,
  output logic                 resp_valid_o,
  output logic [31:0]          resp_rdata_o,
  output logic                 resp_err_o,
  output logic [CNT_WIDTH-1:0] outstnd_cnt_o,
  output logic                 busy_o,
  output logic                 protocol_err_o
);

  localparam logic [CNT_WIDTH-1:0] LP_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

  gasket_state_e        r_state;
  gasket_state_e        w_stateNext;
  obi_inst_req_t        r_heldReq;
  obi_inst_req_t        w_liveReq;
  obi_inst_req_t        w_busReq;
  obi_inst_resp_t       w_resp;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cntNext;
  logic                 r_protocolErr;
  logic                 w_cntFull;
  logic                 w_cntNonZero;
  logic                 w_req;
  logic                 w_ready;
  logic                 w_capture;
  logic                 w_inc;
  logic                 w_dec;

  // Request as presented by the prefetcher this cycle. The low address bits
  // are masked rather than sliced off so the whole input bus stays referenced.
  always_comb begin
    w_liveReq      = '0;
    w_liveReq.addr = {trans_addr_i[31:2], trans_addr_i[1:0] & 2'b00};
    w_liveReq.prot = {trans_priv_i, INSTR_PROT_FETCH};
  end

  // The full flag depends only on the registered count, so a response never
  // reopens trans_ready_o in the same cycle it arrives.
  assign w_cntFull    = (r_cnt == LP_MAX);
  assign w_cntNonZero = (r_cnt != '0);

  // FSM next-state and address-phase outputs. TRANSPARENT passes the
  // prefetcher request straight through; if it is accepted but not granted we
  // latch it and replay the held copy in REGISTERED until the grant arrives.
  always_comb begin
    w_stateNext = r_state;
    w_req       = 1'b0;
    w_ready     = 1'b0;
    w_busReq    = r_heldReq;
    w_capture   = 1'b0;
    case (r_state)
      TRANSPARENT: begin
        w_req    = trans_valid_i & ~w_cntFull;
        w_ready  = ~w_cntFull;
        w_busReq = w_liveReq;
        if (trans_valid_i && w_ready && !obi_gnt_i) begin
          w_capture   = 1'b1;
          w_stateNext = REGISTERED;
        end
      end
      REGISTERED: begin
        w_req    = 1'b1;
        w_ready  = 1'b0;
        w_busReq = r_heldReq;
        if (obi_gnt_i) begin
          w_stateNext = TRANSPARENT;
        end
      end
      default: begin
        w_stateNext = TRANSPARENT;
      end
    endcase
  end

  // Outstanding counter next value. A grant and a response in the same cycle
  // cancel out; the saturation guard keeps the count from ever passing the
  // limit even though the request gating already prevents that.
  always_comb begin
    w_inc     = w_req & obi_gnt_i;
    w_dec     = obi_rvalid_i & w_cntNonZero;
    w_cntNext = r_cnt;
    if (w_inc && !w_dec && !w_cntFull) begin
      w_cntNext = r_cnt + CNT_WIDTH'(1);
    end else if (w_dec && !w_inc) begin
      w_cntNext = r_cnt - CNT_WIDTH'(1);
    end
  end

  // State, held request, counter and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= TRANSPARENT;
      r_heldReq     <= '0;
      r_cnt         <= '0;
      r_protocolErr <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      if (w_capture) begin
        r_heldReq <= w_liveReq;
      end
      if (obi_rvalid_i && !w_cntNonZero) begin
        r_protocolErr <= 1'b1;
      end
    end
  end

  // Responses pass through combinationally; only the valid is qualified.
  always_comb begin
    w_resp.rdata = obi_rdata_i;
    w_resp.err   = obi_err_i;
  end

  assign obi_req_o      = w_req;
  assign obi_addr_o     = w_busReq.addr;
  assign obi_prot_o     = w_busReq.prot;
  assign trans_ready_o  = w_ready;
  assign resp_valid_o   = obi_rvalid_i & w_cntNonZero;
  assign resp_rdata_o   = w_resp.rdata;
  assign resp_err_o     = w_resp.err;
  assign outstnd_cnt_o  = r_cnt;
  assign busy_o         = w_cntNonZero | (r_state == REGISTERED);
  assign protocol_err_o = r_protocolErr;

endmodule
